// File: rtl/lzx_cla_seq_adder.sv
// Multi-cycle add/subtract: one SLICE_W-bit lookahead slice per clock, carry rippled through a register.
// Latency NSLICE+1 edges from accepted start to done; start is ignored outside IDLE (no queueing).
module lzx_cla_seq_adder #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4,
  localparam int NSLICE = WIDTH / SLICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Cin,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  S,
  output logic              Cout,
  output logic              OVF,
  output logic              G,
  output logic              P,
  output logic [NSLICE-1:0] C
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, bx_q, bx_d, res_q, res_d;
  logic                carry_q, carry_d, g_acc_q, g_acc_d, p_acc_q, p_acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NSLICE-1:0]   c_int_q, c_int_d;
  logic [WIDTH-1:0]    s_q, s_d;
  logic                cout_q, cout_d, ovf_q, ovf_d, g_q, g_d, p_q, p_d;
  logic [NSLICE-1:0]   c_q, c_d;

  logic [SLICE_W-1:0]  a_sl, b_sl, g_sl, p_sl, sum_sl;
  logic [SLICE_W:0]    cv;
  logic                gs, ps;
  int                  base;

  // Lookahead slice for the current index; only consumed while in RUN.
  always_comb begin
    base = int'(idx_q) * SLICE_W;
    a_sl = a_q[base +: SLICE_W];
    b_sl = bx_q[base +: SLICE_W];
    g_sl = a_sl & b_sl;
    p_sl = a_sl ^ b_sl;
    cv   = '0;
    cv[0] = carry_q;
    gs   = 1'b0;
    for (int j = 0; j < SLICE_W; j++) begin
      cv[j+1] = g_sl[j] | (p_sl[j] & cv[j]);
      gs      = g_sl[j] | (p_sl[j] & gs);
    end
    ps     = &p_sl;
    sum_sl = p_sl ^ cv[SLICE_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    res_d   = res_q;
    carry_d = carry_q;
    g_acc_d = g_acc_q;
    p_acc_d = p_acc_q;
    idx_d   = idx_q;
    c_int_d = c_int_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    g_d     = g_q;
    p_d     = p_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          bx_d    = sub ? ~B : B;
          carry_d = Cin ^ sub;
          g_acc_d = 1'b0;
          p_acc_d = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[base +: SLICE_W] = sum_sl;
        c_int_d[idx_q]         = carry_q;
        carry_d                = cv[SLICE_W];
        g_acc_d                = gs | (ps & g_acc_q);
        p_acc_d                = p_acc_q & ps;
        if (idx_q == LAST_IDX) begin
          // Publish everything at once so no partial result is ever visible.
          idx_d   = '0;
          state_d = DONE;
          s_d     = res_d;
          cout_d  = cv[SLICE_W];
          ovf_d   = cv[SLICE_W-1] ^ cv[SLICE_W];
          g_d     = g_acc_d;
          p_d     = p_acc_d;
          c_d     = c_int_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      g_acc_q <= 1'b0;
      p_acc_q <= 1'b0;
      idx_q   <= '0;
      c_int_q <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      g_acc_q <= g_acc_d;
      p_acc_q <= p_acc_d;
      idx_q   <= idx_d;
      c_int_q <= c_int_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      g_q     <= g_d;
      p_q     <= p_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign OVF  = ovf_q;
  assign G    = g_q;
  assign P    = p_q;
  assign C    = c_q;

endmodule

// File: tb/tb_lzx_cla_seq_adder.sv
// Directed bench for lzx_cla_seq_adder (WIDTH=16, SLICE_W=4) with hand-computed expectations.
module tb_lzx_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst, start, Cin, sub;
  logic [15:0] A, B;
  logic        busy, done, Cout, OVF, G, P;
  logic [15:0] S;
  logic [3:0]  C;

  int total = 0;
  int bad   = 0;

  lzx_cla_seq_adder #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .OVF(OVF), .G(G), .P(P), .C(C)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic sb, input logic [15:0] prev_s,
                    input logic [15:0] es, input logic ec, input logic eo,
                    input logic eg, input logic ep, input logic [3:0] ecv);
    int lat;
    A = a; B = b; Cin = cin; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".hold_s"}, S, prev_s);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, 4);
    chk({tag, ".s"}, S, es);
    chk({tag, ".cout"}, Cout, ec);
    chk({tag, ".ovf"}, OVF, eo);
    chk({tag, ".g"}, G, eg);
    chk({tag, ".p"}, P, ep);
    chk({tag, ".c"}, C, ecv);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int tdone[$];

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.s", S, 0);
    chk("rst.flags", {Cout, OVF, G, P}, 0);
    chk("rst.c", C, 0);

    //    tag       A         B         cin   sub   prev_s    S         Co    OVF   G     P     C
    op("add1",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h0000, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110);
    op("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h2233, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1110);
    op("ovfp",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110);
    op("prop",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
    op("sub1",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    op("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001);

    // start held high: accepts every NSLICE+2 cycles, one done per accept
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (done) tdone.push_back(cyc);
    end
    start = 1'b0;
    chk("held.count", tdone.size(), 3);
    if (tdone.size() == 3) begin
      chk("held.first", tdone[0], 5);
      chk("held.gap1", tdone[1] - tdone[0], 6);
      chk("held.gap2", tdone[2] - tdone[1], 6);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("held.s", S, 16'h3333);
    chk("held.idle", {busy, done}, 0);

    // reset in the 2nd RUN cycle aborts the operation
    A = 16'h0F0F; B = 16'h0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.s", S, 0);
    chk("abort.flags", {done, Cout, OVF, G, P}, 0);
    chk("abort.c", C, 0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort.no_done", ndone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
